// File: rtl/thracc_pkg.sv
// rtl/thracc_pkg.sv - shared state type and saturating-add helper for threshold_accumulator
package thracc_pkg;

  typedef enum logic {
    ACC  = 1'b0,
    EMIT = 1'b1
  } state_e;

  localparam int unsigned MAX_ADD_W = 32;

  // Unsigned add of two values clamped to the largest value representable in 'width' bits.
  function automatic logic [MAX_ADD_W-1:0] sat_add(input logic [MAX_ADD_W-1:0] a,
                                                  input logic [MAX_ADD_W-1:0] b,
                                                  input int unsigned          width);
    logic [MAX_ADD_W:0] full;
    logic [MAX_ADD_W:0] lim;
    full = {1'b0, a} + {1'b0, b};
    lim  = ((MAX_ADD_W+1)'(1) << width) - (MAX_ADD_W+1)'(1);
    sat_add = (full > lim) ? lim[MAX_ADD_W-1:0] : full[MAX_ADD_W-1:0];
  endfunction

endpackage

// File: rtl/threshold_accumulator_if.sv
// rtl/threshold_accumulator_if.sv - beat input, packet output and flush signals of threshold_accumulator
interface threshold_accumulator_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned SUM_W  = 10,
  parameter int unsigned CNT_W  = 5
);
  logic              valid_i;
  logic [DATA_W-1:0] data_i;
  logic              ready_o;
  logic              flush_i;
  logic              valid_o;
  logic              ready_i;
  logic [SUM_W-1:0]  sum_o;
  logic [CNT_W-1:0]  count_o;
  logic              sat_o;

  // Producer/consumer side
  modport master (
    output valid_i, data_i, flush_i, ready_i,
    input  ready_o, valid_o, sum_o, count_o, sat_o
  );

  // Accumulator side
  modport slave (
    input  valid_i, data_i, flush_i, ready_i,
    output ready_o, valid_o, sum_o, count_o, sat_o
  );
endinterface

// File: rtl/sat_adder.sv
// rtl/sat_adder.sv - combinational unsigned saturating adder with overflow flag
module sat_adder #(
  parameter int unsigned W = 10
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_o,
  output logic         ovf_o
);

  logic [W:0] raw;

  // Carry-out of the full-width add marks overflow and forces the all-ones clamp
  always_comb begin
    raw   = {1'b0, a_i} + {1'b0, b_i};
    ovf_o = raw[W];
    sum_o = raw[W] ? {W{1'b1}} : raw[W-1:0];
  end

endmodule

// File: rtl/threshold_accumulator.sv
// rtl/threshold_accumulator.sv - streaming accumulator emitting sum/count/sat packets on threshold, count limit or flush
module threshold_accumulator
  import thracc_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned SUM_W     = 10,
  parameter int unsigned THRESHOLD = 60,
  parameter int unsigned MAX_COUNT = 16,
  parameter int unsigned CNT_W     = $clog2(MAX_COUNT + 1)
) (
  input logic                    clk,
  input logic                    rst,
  threshold_accumulator_if.slave bus
);

  localparam logic [SUM_W-1:0] THR_V  = SUM_W'(THRESHOLD);
  localparam logic [CNT_W-1:0] MAXC_V = CNT_W'(MAX_COUNT);

  state_e             state_q, state_d;
  logic [SUM_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sat_acc_q, sat_acc_d;
  logic               valid_q, valid_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               sat_q, sat_d;

  logic               ready;
  logic               accept;
  logic               emit;
  logic [SUM_W-1:0]   data_ext;
  logic [SUM_W-1:0]   add_sum;
  logic               add_ovf;
  logic [SUM_W-1:0]   acc_n;
  logic [CNT_W-1:0]   cnt_n;
  logic               sat_n;

  assign data_ext = {{(SUM_W-DATA_W){1'b0}}, bus.data_i};

  sat_adder #(.W(SUM_W)) u_sat_adder (
    .a_i   (acc_q),
    .b_i   (data_ext),
    .sum_o (add_sum),
    .ovf_o (add_ovf)
  );

  // Post-beat values, emit decision and next-state for all registers
  always_comb begin
    // A pending packet drains in the same cycle a new beat may enter
    ready  = (state_q == ACC) || bus.ready_i;
    accept = bus.valid_i && ready;

    // acc/cnt are already zero in EMIT, so a drain-cycle beat starts a fresh packet
    acc_n = accept ? add_sum : acc_q;
    sat_n = sat_acc_q || (accept && add_ovf);
    cnt_n = cnt_q + CNT_W'(accept);

    // Gating with ready keeps a stalled EMIT from reacting to flush
    emit = ready && ((acc_n >= THR_V) || (cnt_n == MAXC_V) ||
                     (bus.flush_i && (cnt_n != '0)));

    state_d   = state_q;
    acc_d     = acc_n;
    cnt_d     = cnt_n;
    sat_acc_d = sat_n;
    valid_d   = valid_q;
    sum_d     = sum_q;
    count_d   = count_q;
    sat_d     = sat_q;

    if (emit) begin
      sum_d     = acc_n;
      count_d   = cnt_n;
      sat_d     = sat_n;
      valid_d   = 1'b1;
      acc_d     = '0;
      cnt_d     = '0;
      sat_acc_d = 1'b0;
      state_d   = EMIT;
    end else if ((state_q == EMIT) && bus.ready_i) begin
      valid_d = 1'b0;
      state_d = ACC;
    end
  end

  // Single register stage for FSM state, accumulator and output holding registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ACC;
      acc_q     <= '0;
      cnt_q     <= '0;
      sat_acc_q <= 1'b0;
      valid_q   <= 1'b0;
      sum_q     <= '0;
      count_q   <= '0;
      sat_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      sat_acc_q <= sat_acc_d;
      valid_q   <= valid_d;
      sum_q     <= sum_d;
      count_q   <= count_d;
      sat_q     <= sat_d;
    end
  end

  assign bus.ready_o = ready;
  assign bus.valid_o = valid_q;
  assign bus.sum_o   = sum_q;
  assign bus.count_o = count_q;
  assign bus.sat_o   = sat_q;

endmodule

// File: tb/tb_threshold_accumulator.sv
// tb/tb_threshold_accumulator.sv - scoreboard bench for threshold_accumulator
module tb_threshold_accumulator;

  typedef struct packed {
    logic [9:0] sum;
    logic [4:0] cnt;
    logic       sat;
  } pkt_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  threshold_accumulator_if #(.DATA_W(8), .SUM_W(10), .CNT_W(5)) bus0 ();
  threshold_accumulator_if #(.DATA_W(8), .SUM_W(10), .CNT_W(5)) bus1 ();

  threshold_accumulator dut0 (.clk(clk), .rst(rst), .bus(bus0));
  threshold_accumulator #(.THRESHOLD(1023)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  pkt_t exp0[$];
  pkt_t exp1[$];
  pkt_t p0, p1;
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic pkt_t mk(input int s, input int c, input logic st);
    pkt_t p;
    p.sum = s[9:0];
    p.cnt = c[4:0];
    p.sat = st;
    return p;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic send0(input logic [7:0] d, input logic fl);
    bus0.valid_i = 1'b1;
    bus0.data_i  = d;
    bus0.flush_i = fl;
    @(posedge clk); #1;
    bus0.valid_i = 1'b0;
    bus0.flush_i = 1'b0;
  endtask

  task automatic send1(input logic [7:0] d, input logic fl);
    bus1.valid_i = 1'b1;
    bus1.data_i  = d;
    bus1.flush_i = fl;
    @(posedge clk); #1;
    bus1.valid_i = 1'b0;
    bus1.flush_i = 1'b0;
  endtask

  // Monitor for dut0: a packet transfers when valid_o && ready_i
  always @(negedge clk) begin
    if (!rst && bus0.valid_o && bus0.ready_i) begin
      if (exp0.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL pkt0 unexpected: got sum=%0d count=%0d, required no packet", bus0.sum_o, bus0.count_o);
      end else begin
        p0 = exp0.pop_front();
        chk("pkt0 sum",   32'(bus0.sum_o),   32'(p0.sum));
        chk("pkt0 count", 32'(bus0.count_o), 32'(p0.cnt));
        chk("pkt0 sat",   32'(bus0.sat_o),   32'(p0.sat));
      end
    end
  end

  // Monitor for dut1
  always @(negedge clk) begin
    if (!rst && bus1.valid_o && bus1.ready_i) begin
      if (exp1.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL pkt1 unexpected: got sum=%0d count=%0d, required no packet", bus1.sum_o, bus1.count_o);
      end else begin
        p1 = exp1.pop_front();
        chk("pkt1 sum",   32'(bus1.sum_o),   32'(p1.sum));
        chk("pkt1 count", 32'(bus1.count_o), 32'(p1.cnt));
        chk("pkt1 sat",   32'(bus1.sat_o),   32'(p1.sat));
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus0.valid_i = 1'b0; bus0.data_i = '0; bus0.flush_i = 1'b0; bus0.ready_i = 1'b1;
    bus1.valid_i = 1'b0; bus1.data_i = '0; bus1.flush_i = 1'b0; bus1.ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset valid_o", 32'(bus0.valid_o), 0);
    chk("reset sum_o",   32'(bus0.sum_o),   0);
    chk("reset count_o", 32'(bus0.count_o), 0);
    chk("reset sat_o",   32'(bus0.sat_o),   0);
    chk("reset ready_o", 32'(bus0.ready_o), 1);
    chk("reset valid_o dut1", 32'(bus1.valid_o), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Threshold: 15+20+25 = 60, twelve back-to-back triples
    for (int i = 0; i < 12; i++) begin
      send0(8'd15, 1'b0);
      send0(8'd20, 1'b0);
      exp0.push_back(mk(60, 3, 1'b0));
      send0(8'd25, 1'b0);
      if (i == 0) begin
        chk("latency valid_o", 32'(bus0.valid_o), 1);
        chk("latency sum_o",   32'(bus0.sum_o),   60);
      end
    end

    // Count limit: 1,2,3 repeating -> 31/16 then 32/16
    for (int i = 0; i < 32; i++) begin
      if (i == 15) exp0.push_back(mk(31, 16, 1'b0));
      if (i == 31) exp0.push_back(mk(32, 16, 1'b0));
      send0(8'((i % 3) + 1), 1'b0);
    end

    // Backpressure: hold 60/3 while ready_i=0, then drain and accept together
    send0(8'd15, 1'b0);
    send0(8'd20, 1'b0);
    exp0.push_back(mk(60, 3, 1'b0));
    send0(8'd25, 1'b0);
    bus0.ready_i = 1'b0;
    bus0.valid_i = 1'b1;
    bus0.data_i  = 8'd7;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp ready_o", 32'(bus0.ready_o), 0);
      chk("bp valid_o", 32'(bus0.valid_o), 1);
      chk("bp sum_o",   32'(bus0.sum_o),   60);
      chk("bp count_o", 32'(bus0.count_o), 3);
      @(posedge clk); #1;
    end
    bus0.ready_i = 1'b1;
    #1;
    chk("drain ready_o", 32'(bus0.ready_o), 1);
    @(posedge clk); #1;
    bus0.valid_i = 1'b0;
    chk("after drain valid_o", 32'(bus0.valid_o), 0);
    exp0.push_back(mk(60, 2, 1'b0));
    send0(8'd53, 1'b0);

    // Flush without a beat, flush with a beat, flush while empty
    send0(8'd10, 1'b0);
    send0(8'd20, 1'b0);
    exp0.push_back(mk(30, 2, 1'b0));
    bus0.flush_i = 1'b1;
    @(posedge clk); #1;
    bus0.flush_i = 1'b0;
    send0(8'd10, 1'b0);
    exp0.push_back(mk(15, 2, 1'b0));
    send0(8'd5, 1'b1);
    bus0.flush_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus0.flush_i = 1'b0;
    @(negedge clk);
    chk("empty flush valid_o", 32'(bus0.valid_o), 0);

    // Saturation on the THRESHOLD=1023 instance
    for (int i = 0; i < 5; i++) begin
      if (i == 4) exp1.push_back(mk(1023, 5, 1'b1));
      send1(8'd255, 1'b0);
    end
    send1(8'd255, 1'b0);
    send1(8'd255, 1'b0);
    send1(8'd255, 1'b0);
    exp1.push_back(mk(1020, 4, 1'b0));
    send1(8'd255, 1'b1);
    repeat (3) @(posedge clk);
    #1;

    // Reset while a packet is stalled in EMIT
    bus0.ready_i = 1'b0;
    send0(8'd15, 1'b0);
    send0(8'd20, 1'b0);
    send0(8'd25, 1'b0);
    chk("pre-reset valid_o", 32'(bus0.valid_o), 1);
    chk("pre-reset sum_o",   32'(bus0.sum_o),   60);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst emit valid_o", 32'(bus0.valid_o), 0);
    chk("rst emit sum_o",   32'(bus0.sum_o),   0);
    chk("rst emit count_o", 32'(bus0.count_o), 0);
    chk("rst emit ready_o", 32'(bus0.ready_o), 1);
    bus0.ready_i = 1'b1;
    send0(8'd15, 1'b0);
    send0(8'd20, 1'b0);
    exp0.push_back(mk(60, 3, 1'b0));
    send0(8'd25, 1'b0);

    // Bounded wait for the scoreboards to empty
    for (int i = 0; i < 50; i++) begin
      if (exp0.size() == 0 && exp1.size() == 0) break;
      @(posedge clk);
    end
    repeat (3) @(posedge clk);
    chk("pending pkts dut0", 32'(exp0.size()), 0);
    chk("pending pkts dut1", 32'(exp1.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/threshold_accumulator.md
Name: threshold_accumulator

Overview:
- Streaming accumulator: sums accepted input beats and emits one result packet (sum, beat count, saturation flag) when any of these occurs:
  - the running sum reaches THRESHOLD;
  - MAX_COUNT beats have been accepted;
  - a flush is requested.
- Valid/ready handshake on both input and output sides; full output backpressure.
- Successor to the fixed-threshold ornek1 accumulator: generalised widths, count limit, flush, saturation and output backpressure.
- Sits between a byte-stream producer and a packet consumer.

Parameters:
- DATA_W, 8, input data width.
- SUM_W, 10, accumulator/sum_o width; must be > DATA_W.
- THRESHOLD, 60, emit when running sum >= THRESHOLD; legal range 1..2^SUM_W-1.
- MAX_COUNT, 16, emit when this many beats have been accepted; legal range >= 1.
- CNT_W, $clog2(MAX_COUNT+1), width of count_o.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- valid_i  in  1  input beat valid.
- data_i  in  DATA_W  input data, unsigned.
- ready_o  out  1  block can accept a beat.
- flush_i  in  1  force emit of partial sum (single-cycle pulse or level).
- valid_o  out  1  result packet valid.
- ready_i  in  1  downstream accepts the packet.
- sum_o  out  SUM_W  packet sum.
- count_o  out  CNT_W  number of beats in the packet.
- sat_o  out  1  sum saturated during this packet.

Behaviour:
- Reset (rst=1 at a clk edge):
  - acc, cnt, sat_acc cleared; state=ACC.
  - Outputs after reset: valid_o=0, sum_o=0, count_o=0, sat_o=0, ready_o=1.
  - Reset mid-packet or during EMIT discards all data; no packet is emitted.
- States:
  - ACC: accumulating.
  - EMIT: packet registered on the outputs, waiting for ready_i.
- ready_o = (state==ACC) || ready_i. This is combinational from ready_i: a new beat may be accepted in the same cycle the pending packet drains.
- Accept: accept = valid_i && ready_o. On accept:
  - acc_n = acc + data_i, saturating at 2^SUM_W-1; sat_n = sat_acc || overflow.
  - cnt_n = cnt + 1.
- Emit condition, evaluated on the post-beat values:
  - acc_n >= THRESHOLD; or
  - cnt_n == MAX_COUNT; or
  - flush_i && cnt_n != 0.
- Flush:
  - If flush_i arrives in the same cycle as an accepted beat, that beat is included in the flushed packet.
  - flush_i with cnt_n==0 is ignored.
  - flush_i is ignored while in EMIT without drain.
- On emit, at the clock edge:
  - sum_o<=acc_n, count_o<=cnt_n, sat_o<=sat_n, valid_o<=1.
  - acc, cnt, sat_acc cleared to 0.
  - state<=EMIT.
- Latency: valid_o rises on the clock edge after the beat that triggers the emit is presented, i.e. one cycle.
- Without emit: acc<=acc_n, cnt<=cnt_n, sat_acc<=sat_n; state unchanged.
- In EMIT:
  - sum_o, count_o and sat_o hold stable while valid_o=1 && ready_i=0.
  - On ready_i=1 without an accept: valid_o<=0, state<=ACC.
- Simultaneous drain and accept (EMIT, ready_i=1, valid_i=1):
  - The beat starts the new packet from acc=0.
  - If that single beat meets the emit condition (data_i >= THRESHOLD, MAX_COUNT==1, or flush_i), valid_o stays 1 with the new values; back-to-back packets are allowed.
- A single beat >= THRESHOLD emits a 1-beat packet.
- Output holding registers retain their last values after a drain. Consumers qualify them with valid_o.
- Arithmetic: all values unsigned; data_i is zero-extended to SUM_W before the add.

Decomposition:
- Shared package, thracc_pkg:
  - state enum {ACC, EMIT};
  - saturating-add function sat_add(a, b, width).
- Natural sub-module: sat_adder (combinational saturating adder, parametrised width, carry-out used as the overflow flag).
- Control, counters and output registers stay in the top module.

Test Plan:
- Defaults, ready_i=1: beats 15, 20, 25 on consecutive cycles -> one cycle after the 25 beat, valid_o=1, sum_o=60, count_o=3, sat_o=0; repeating the triple 12 times yields 12 identical packets with no lost beats.
- Defaults, ready_i=1: repeating pattern 1, 2, 3 -> packet after 16 beats with sum_o=31, count_o=16 (count limit); the next packet starts with beat 2 and also has count_o=16.
- Backpressure:
  - Beats 15, 20, 25, then ready_i=0 for 5 cycles with valid_i=1 -> ready_o=0, and sum_o=60, count_o=3 stable all 5 cycles.
  - Raising ready_i drains the packet and accepts the next beat in the same cycle.
- Flush:
  - Beats 10, 20 then flush_i=1 with no beat -> packet sum_o=30, count_o=2.
  - flush_i together with beat 5 after beat 10 -> sum_o=15, count_o=2.
  - flush_i while empty -> no packet.
- Saturation, THRESHOLD=1023: beats 255, 255, 255, 255, 255 -> packet sum_o=1023, count_o=5, sat_o=1; the next packet has sat_o=0.
- Reset during EMIT with ready_i=0 -> next cycle valid_o=0, sum_o=0, count_o=0, ready_o=1; a following 15, 20, 25 sequence produces a clean 60/3 packet.
